// File: rtl/rot_cmd_sequencer.sv
// Command sequencer driving a 4-bit left/right rotate register (Left_in/Right_in/data_in).
// Latency: accept edge to done pulse = cmd_load + steps + 1 cycles; outputs are a Moore decode.
// Backpressure: cmd_ready high only in IDLE; cmd_valid while busy stays pending.
// Optional build macro ROT_SEQ_SHORTEST_EN: reduce each rotation to the shortest direction/step count.
module rot_cmd_sequencer #(
    parameter int DATA_WIDTH = 4,
    parameter int CNT_WIDTH  = 4,
    parameter int POS_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_load,
    input  logic                  cmd_dir,
    input  logic [CNT_WIDTH-1:0]  cmd_count,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  Left_out,
    output logic                  Right_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  done,
    output logic [POS_WIDTH-1:0]  pos
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ROT  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [POS_WIDTH-1:0] POS_MAX = POS_WIDTH'(DATA_WIDTH - 1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic [POS_WIDTH-1:0]  pos_q, pos_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  dir_q, dir_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic                  accept;
    logic                  acc_dir;
    logic [CNT_WIDTH-1:0]  acc_cnt;

    assign accept = cmd_valid && (state_q == IDLE);

`ifdef ROT_SEQ_SHORTEST_EN
    logic [31:0] eff;

    // Fold the requested count modulo the width and pick the shorter way round.
    always_comb begin
        eff     = 32'(cmd_count) % 32'(DATA_WIDTH);
        acc_dir = cmd_dir;
        acc_cnt = CNT_WIDTH'(eff);
        if (eff > 32'(DATA_WIDTH / 2)) begin
            acc_dir = ~cmd_dir;
            acc_cnt = CNT_WIDTH'(32'(DATA_WIDTH) - eff);
        end
    end
`else
    // Counts larger than the width are executed literally, one step per cycle.
    always_comb begin
        acc_dir = cmd_dir;
        acc_cnt = cmd_count;
    end
`endif

    // State, shadow and captured-command registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            pos_q    <= '0;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            pos_q    <= pos_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            data_q   <= data_d;
        end
    end

    // Next-state logic; shadow tracks exactly what the rotator will hold after each edge.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        pos_d    = pos_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        data_d   = data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d = cmd_data;
                    dir_d  = acc_dir;
                    cnt_d  = acc_cnt;
                    if (cmd_load) begin
                        state_d = LOAD;
                    end else if (acc_cnt == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = ROT;
                    end
                end
            end
            LOAD: begin
                shadow_d = data_q;
                pos_d    = '0;
                state_d  = (cnt_q == '0) ? DONE : ROT;
            end
            ROT: begin
                if (!dir_q) begin
                    shadow_d = {shadow_q[DATA_WIDTH-2:0], shadow_q[DATA_WIDTH-1]};
                    pos_d    = (pos_q == POS_MAX) ? '0 : pos_q + 1'b1;
                end else begin
                    shadow_d = {shadow_q[0], shadow_q[DATA_WIDTH-1:1]};
                    pos_d    = (pos_q == '0) ? POS_MAX : pos_q - 1'b1;
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_WIDTH'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore output decode; idle cycles feed the shadow back so the rotator holds.
    always_comb begin
        Left_out  = 1'b0;
        Right_out = 1'b0;
        data_out  = shadow_q;
        done      = 1'b0;
        case (state_q)
            LOAD: data_out = data_q;
            ROT: begin
                Left_out  = ~dir_q;
                Right_out = dir_q;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign cmd_ready = (state_q == IDLE);
    assign pos       = pos_q;

endmodule

// File: tb/tb_rot_cmd_sequencer.sv
// Directed bench for rot_cmd_sequencer with a behavioural 4-bit rotator downstream.
// Table of commands with hand-computed rotator/pos results, plus hold-valid and mid-command reset sequences.
// Every wait on the DUT is bounded by a cycle budget.
module tb_rot_cmd_sequencer;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_load = 1'b0;
    logic       cmd_dir = 1'b0;
    logic [3:0] cmd_count = 4'd0;
    logic [3:0] cmd_data = 4'd0;
    logic       Left_out, Right_out;
    logic [3:0] data_out;
    logic       busy, done;
    logic [1:0] pos;

    int checks = 0;
    int errors = 0;

    rot_cmd_sequencer #(.DATA_WIDTH(4), .CNT_WIDTH(4), .POS_WIDTH(2)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_load  (cmd_load),
        .cmd_dir   (cmd_dir),
        .cmd_count (cmd_count),
        .cmd_data  (cmd_data),
        .Left_out  (Left_out),
        .Right_out (Right_out),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done),
        .pos       (pos)
    );

    always #5 clk = ~clk;

    // Downstream rotate register as the sequencer expects to find it.
    logic [3:0] rot_q;
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rot_q <= 4'b0000;
        end else begin
            case ({Right_out, Left_out})
                2'b00:   rot_q <= data_out;
                2'b01:   rot_q <= {rot_q[2:0], rot_q[3]};
                2'b10:   rot_q <= {rot_q[0], rot_q[3:1]};
                default: rot_q <= rot_q;
            endcase
        end
    end

    typedef struct {
        logic       load;
        logic       dir;
        int         count;
        logic [3:0] data;
        logic [3:0] exp_rot;
        int         exp_pos;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Expected left/right step counts for a command as built.
    task automatic exp_steps(input logic dir, input int count, output int l, output int r);
        int   steps;
        logic d;
        steps = count;
        d     = dir;
`ifdef ROT_SEQ_SHORTEST_EN
        steps = count % 4;
        if (steps > 2) begin
            d     = ~dir;
            steps = 4 - steps;
        end
`endif
        l = d ? 0 : steps;
        r = d ? steps : 0;
    endtask

    task automatic run_cmd(input vec_t v, input string tag);
        int   lat, lc, rc, both, el, er;
        logic seen;
        exp_steps(v.dir, v.count, el, er);
        lat = 0; lc = 0; rc = 0; both = 0; seen = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_load  = v.load;
        cmd_dir   = v.dir;
        cmd_count = 4'(v.count);
        cmd_data  = v.data;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (i == 0) cmd_valid = 1'b0;
            lat++;
            if (Left_out && Right_out) both++;
            lc += int'(Left_out);
            rc += int'(Right_out);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, " done_seen"}, int'(seen), 1);
        check({tag, " latency"}, lat, int'(v.load) + el + er + 1);
        check({tag, " left_steps"}, lc, el);
        check({tag, " right_steps"}, rc, er);
        check({tag, " both_high"}, both, 0);
        @(posedge clk); #1;
        check({tag, " ready_idle"}, int'(cmd_ready), 1);
        check({tag, " rotator"}, int'(rot_q), int'(v.exp_rot));
        check({tag, " data_out_hold"}, int'(data_out), int'(v.exp_rot));
        check({tag, " pos"}, int'(pos), v.exp_pos);
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check({tag, " done_seen"}, int'(seen), 1);
    endtask

    initial begin
        vec_t v;
        //            load  dir   cnt data     rot      pos
        vecs[0] = '{1'b1, 1'b0, 2,  4'b0001, 4'b0100, 2};
        vecs[1] = '{1'b0, 1'b1, 5,  4'b0000, 4'b0010, 1};
        vecs[2] = '{1'b0, 1'b0, 0,  4'b0000, 4'b0010, 1};
        vecs[3] = '{1'b1, 1'b1, 0,  4'b1011, 4'b1011, 0};
        vecs[4] = '{1'b0, 1'b0, 3,  4'b0000, 4'b1101, 3};
        vecs[5] = '{1'b0, 1'b0, 6,  4'b0000, 4'b0111, 1};
        vecs[6] = '{1'b1, 1'b1, 1,  4'b1000, 4'b0100, 3};
        vecs[7] = '{1'b0, 1'b1, 15, 4'b0000, 4'b1000, 0};

        // Reset state.
        #1;
        check("rst Left_out", int'(Left_out), 0);
        check("rst Right_out", int'(Right_out), 0);
        check("rst data_out", int'(data_out), 0);
        check("rst cmd_ready", int'(cmd_ready), 1);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst pos", int'(pos), 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;

        for (int k = 0; k < 8; k++) begin
            run_cmd(vecs[k], $sformatf("vec%0d", k));
        end

        // cmd_valid held high: second command waits until the IDLE after done.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_dir = 1'b0; cmd_count = 4'd3;
        @(posedge clk); #1;
        cmd_dir = 1'b1; cmd_count = 4'd1;
        check("hold busy", int'(busy), 1);
        for (int i = 0; i < 50 && !done; i++) begin
            check("hold ready_low", int'(cmd_ready), 0);
            @(posedge clk); #1;
        end
        check("hold first_done", int'(done), 1);
        @(posedge clk); #1;
        check("hold idle_ready", int'(cmd_ready), 1);
        check("hold mid_rot", int'(rot_q), 4'b0100);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("hold second_accept", int'(Right_out), 1);
        check("hold second_busy", int'(busy), 1);
        wait_done("hold second");
        @(posedge clk); #1;
        check("hold final_rot", int'(rot_q), 4'b0010);
        check("hold final_pos", int'(pos), 2);

        // Reset asserted during the second ROT cycle.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_dir = 1'b0; cmd_count = 4'd2; cmd_data = 4'b1111;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("mrst load_data", int'(data_out), 4'b1111);
        check("mrst load_left", int'(Left_out), 0);
        @(posedge clk); #1;
        check("mrst rot1_left", int'(Left_out), 1);
        @(posedge clk); #1;
        check("mrst rot2_left", int'(Left_out), 1);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        check("mrst Left_out", int'(Left_out), 0);
        check("mrst Right_out", int'(Right_out), 0);
        check("mrst data_out", int'(data_out), 0);
        check("mrst done", int'(done), 0);
        check("mrst busy", int'(busy), 0);
        check("mrst cmd_ready", int'(cmd_ready), 1);
        check("mrst pos", int'(pos), 0);
        check("mrst rotator", int'(rot_q), 0);
        @(negedge clk);
        n_rst = 1'b1;
        v = '{1'b1, 1'b0, 1, 4'b0110, 4'b1100, 1};
        run_cmd(v, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
